// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
//
// Hazard scheduler for the 5-stage PCPU. It keeps a small copy of the
// destination information of the instructions in EX and MEM. From that copy
// it produces, for the instruction in ID:
//   - operand forwarding selects,
//   - load-use and mul/div stalls,
//   - the flush for a taken branch or a jump.
// It also sequences the iterative mul/div unit with a busy counter.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   id_rs, id_rt      source register fields of the ID instruction
//   id_use_rs/rt      ID instruction actually reads rs / rt
//   id_wreg           ID instruction writes the register file
//   id_mem2reg        ID instruction is a load
//   id_dest           ID destination register (after regrt/jal mux)
//   id_branch_taken   branch resolved taken in ID
//   id_jump           ID instruction is j/jal/jr
//   id_muldiv         ID instruction issues a mul/div
//   id_use_hilo       ID instruction reads HI/LO
//   fwda, fwdb        operand selects:
//                       00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
//   stall             hold PC and IF/ID; inject a bubble into ID/EX
//   flush             squash the instruction in IF/ID
//   md_start          one-cycle issue strobe to the mul/div unit
//   md_busy           mul/div unit occupied
//   md_done           one-cycle pulse on the last busy cycle
//
// MD_CYCLES must be at least 1. CNT_W must be wide enough to hold MD_CYCLES.
// -----------------------------------------------------------------------------
module hazard_sched #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wreg,
  input  logic       id_mem2reg,
  input  logic [4:0] id_dest,
  input  logic       id_branch_taken,
  input  logic       id_jump,
  input  logic       id_muldiv,
  input  logic       id_use_hilo,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       stall,
  output logic       flush,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
);

  // Operand source encoding shared by fwda and fwdb.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  // EX and MEM stage records.
  logic       e_wreg_q, e_m2r_q;
  logic [4:0] e_dest_q;
  logic       m_wreg_q, m_m2r_q;
  logic [4:0] m_dest_q;

  logic       e_wreg_d, e_m2r_d;
  logic [4:0] e_dest_d;

  // Mul/div busy counter: counts down the remaining occupied cycles.
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic lu;  // load-use hazard
  logic ms;  // mul/div hazard

  // Forward select for one source register. The EX match is checked first,
  // so it wins when EX and MEM both hold the same destination. A load in EX
  // cannot forward because its data does not exist yet; that case is
  // covered by the load-use stall instead. Register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       ew,
    input logic       em,
    input logic [4:0] ed,
    input logic       mw,
    input logic       mm,
    input logic [4:0] md
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ew && (ed != 5'd0) && (ed == src) && !em) begin
      sel = FWD_EX;
    end else if (mw && (md != 5'd0) && (md == src)) begin
      sel = mm ? FWD_LD : FWD_MEM;
    end
    return sel;
  endfunction

  // The selects follow the rule even when the operand is not read; the
  // datapath ignores them in that case.
  assign fwda = fwd_sel(id_rs, e_wreg_q, e_m2r_q, e_dest_q,
                        m_wreg_q, m_m2r_q, m_dest_q);
  assign fwdb = fwd_sel(id_rt, e_wreg_q, e_m2r_q, e_dest_q,
                        m_wreg_q, m_m2r_q, m_dest_q);

  // Unlike forwarding, the load-use stall only fires for operands that are
  // actually read, so that unused fields do not cost a cycle.
  assign lu = e_wreg_q && e_m2r_q && (e_dest_q != 5'd0) &&
              ((id_use_rs && (e_dest_q == id_rs)) ||
               (id_use_rt && (e_dest_q == id_rt)));

  assign md_busy = (md_cnt_q != '0);
  assign md_done = (md_cnt_q == CNT_W'(1));

  // A new mul/div and any HI/LO reader both wait for the unit to drain.
  // This also guarantees md_start never overlaps a busy unit.
  assign ms = md_busy && (id_muldiv || id_use_hilo);

  assign stall = lu || ms;

  // A stalled branch stays in ID and is re-evaluated next cycle, so the
  // flush is held back until the stall clears.
  assign flush    = (id_branch_taken || id_jump) && !stall;
  assign md_start = id_muldiv && !stall;

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    e_wreg_d = id_wreg;
    e_m2r_d  = id_mem2reg;
    e_dest_d = id_dest;
    md_cnt_d = md_cnt_q;

    // The bubble injected on a stall must not write the register file,
    // otherwise it would create a phantom forwarding source.
    if (stall) begin
      e_wreg_d = 1'b0;
      e_m2r_d  = 1'b0;
      e_dest_d = 5'd0;
    end

    if (md_start) begin
      md_cnt_d = CNT_W'(MD_CYCLES);
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  // State registers. Reset clears the records and aborts any mul/div
  // without producing a done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge value, independent of statement order.
    if (rst) begin
      e_wreg_q <= 1'b0;
      e_m2r_q  <= 1'b0;
      e_dest_q <= 5'd0;
      m_wreg_q <= 1'b0;
      m_m2r_q  <= 1'b0;
      m_dest_q <= 5'd0;
      md_cnt_q <= '0;
    end else begin
      m_wreg_q <= e_wreg_q;
      m_m2r_q  <= e_m2r_q;
      m_dest_q <= e_dest_q;
      e_wreg_q <= e_wreg_d;
      e_m2r_q  <= e_m2r_d;
      e_dest_q <= e_dest_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// -----------------------------------------------------------------------------
// tb_hazard_sched
//
// Directed bench for hazard_sched. The main instance runs with MD_CYCLES=4.
// A second instance with MD_CYCLES=1 shares the same inputs and is checked
// in the single-cycle mul/div segment at the end. Inputs change on the
// falling edge, the expected outputs for that cycle go into a scoreboard
// queue, and they are popped and compared 1 ns later, well away from the
// rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_wreg, id_mem2reg;
  logic       id_branch_taken, id_jump, id_muldiv, id_use_hilo;

  logic [1:0] fwda, fwdb;
  logic       stall, flush, md_start, md_busy, md_done;

  logic [1:0] u1_fwda, u1_fwdb;
  logic       u1_stall, u1_flush, u1_md_start, u1_md_busy, u1_md_done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       fl;
    logic       ms;
    logic       mb;
    logic       md;
  } exp_t;

  exp_t sb[$];
  logic [4:0] rdest;

  always #5 clk = ~clk;

  hazard_sched #(.MD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_mem2reg(id_mem2reg), .id_dest(id_dest),
    .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .id_muldiv(id_muldiv), .id_use_hilo(id_use_hilo),
    .fwda(fwda), .fwdb(fwdb), .stall(stall), .flush(flush),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
  );

  hazard_sched #(.MD_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_mem2reg(id_mem2reg), .id_dest(id_dest),
    .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .id_muldiv(id_muldiv), .id_use_hilo(id_use_hilo),
    .fwda(u1_fwda), .fwdb(u1_fwdb), .stall(u1_stall), .flush(u1_flush),
    .md_start(u1_md_start), .md_busy(u1_md_busy), .md_done(u1_md_done)
  );

  task automatic check(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Set the ID instruction fields; control strobes return to 0.
  task automatic id(input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt,
                    input logic wr, input logic m2r, input logic [4:0] dst);
    id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
    id_wreg = wr;  id_mem2reg = m2r;  id_dest = dst;
    id_branch_taken = 1'b0;  id_jump = 1'b0;
    id_muldiv = 1'b0;  id_use_hilo = 1'b0;
  endtask

  task automatic idle();
    id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Push the expectation for this cycle, let the combinational outputs
  // settle, then pop it and compare against the main instance.
  task automatic expect_out(input string tag, input logic [1:0] fa,
                            input logic [1:0] fb, input logic st,
                            input logic fl, input logic ms,
                            input logic mb, input logic md);
    exp_t e;
    sb.push_back('{fa, fb, st, fl, ms, mb, md});
    #1;
    e = sb.pop_front();
    check({tag, ".fwda"},     fwda,     e.fa);
    check({tag, ".fwdb"},     fwdb,     e.fb);
    check({tag, ".stall"},    stall,    e.st);
    check({tag, ".flush"},    flush,    e.fl);
    check({tag, ".md_start"}, md_start, e.ms);
    check({tag, ".md_busy"},  md_busy,  e.mb);
    check({tag, ".md_done"},  md_done,  e.md);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    rdest = 5'd1;
    @(posedge clk);

    // Reset with random ID traffic (no control strobes): everything quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      id(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
         1'b1, 1'($urandom), 5'($urandom_range(31, 1)));
      id_use_hilo = 1'($urandom);
      rdest = id_dest;
      expect_out("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    end

    // First cycle after release: E/M were cleared, so the previous dest
    // is not forwarded.
    @(negedge clk); rst = 1'b0;
    id(rdest, rdest, 1, 1, 1, 0, 5'd3);            // add $3
    expect_out("post_rst", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // ALU forwarding from EX then MEM, and register 0.
    @(negedge clk); id(5'd3, 5'd7, 1, 1, 1, 0, 5'd4);  // sub $4,$3,$7
    expect_out("fwd_ex", 2'b01, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd3, 5'd4, 1, 1, 1, 0, 5'd0);  // writes $0
    expect_out("fwd_mem", 2'b10, 2'b01, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd0, 5'd0, 1, 1, 0, 0, 5'd0);
    expect_out("r0_ex", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd0, 5'd0, 1, 1, 0, 0, 5'd0);
    expect_out("r0_mem", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Load-use: lw $5 then add $6,$1,$5.
    @(negedge clk); id(5'd0, 5'd0, 0, 0, 1, 1, 5'd5);
    expect_out("lw5", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd1, 5'd5, 1, 1, 1, 0, 5'd6);
    expect_out("lu_stall", 2'b00, 2'b00, 1, 0, 0, 0, 0);
    @(negedge clk); id(5'd1, 5'd5, 1, 1, 1, 0, 5'd6);
    expect_out("lu_fwd", 2'b00, 2'b11, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd6, 5'd6, 1, 1, 1, 0, 5'd6);
    expect_out("fwd_ex6", 2'b01, 2'b01, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd6, 5'd0, 1, 0, 0, 0, 5'd0);
    expect_out("ex_prio", 2'b01, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd6, 5'd0, 1, 0, 0, 0, 5'd0);
    expect_out("mem_fwd6", 2'b10, 2'b00, 0, 0, 0, 0, 0);

    // Load followed by an instruction that does not read the register.
    @(negedge clk); id(5'd0, 5'd0, 0, 0, 1, 1, 5'd8);
    expect_out("lw8", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd8, 5'd8, 0, 0, 0, 0, 5'd0);
    expect_out("nouse_ex", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd8, 5'd8, 0, 0, 0, 0, 5'd0);
    expect_out("nouse_mem", 2'b11, 2'b11, 0, 0, 0, 0, 0);

    // Branch flush, plain and delayed by a load-use stall; then a jump.
    @(negedge clk); id(5'd0, 5'd0, 1, 1, 0, 0, 5'd0); id_branch_taken = 1'b1;
    expect_out("br", 2'b00, 2'b00, 0, 1, 0, 0, 0);
    @(negedge clk); id(5'd0, 5'd0, 0, 0, 1, 1, 5'd5);
    expect_out("lw5b", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk); id(5'd5, 5'd0, 1, 1, 0, 0, 5'd0); id_branch_taken = 1'b1;
    expect_out("br_lu", 2'b00, 2'b00, 1, 0, 0, 0, 0);
    @(negedge clk); id(5'd5, 5'd0, 1, 1, 0, 0, 5'd0); id_branch_taken = 1'b1;
    expect_out("br_retry", 2'b11, 2'b00, 0, 1, 0, 0, 0);
    @(negedge clk); idle(); id_jump = 1'b1;
    expect_out("jump", 2'b00, 2'b00, 0, 1, 0, 0, 0);

    // Mul/div issue, busy for 4 cycles, mfhi held until the unit drains.
    @(negedge clk); idle(); id_muldiv = 1'b1;
    expect_out("md_issue", 2'b00, 2'b00, 0, 0, 1, 0, 0);
    @(negedge clk); idle();
    expect_out("md_busy1", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); id(5'd0, 5'd0, 0, 0, 1, 0, 5'd2); id_use_hilo = 1'b1;
      expect_out("mfhi_wait", 2'b00, 2'b00, 1, 0, 0, 1, 0);
    end
    @(negedge clk); id(5'd0, 5'd0, 0, 0, 1, 0, 5'd2); id_use_hilo = 1'b1;
    expect_out("mfhi_done", 2'b00, 2'b00, 1, 0, 0, 1, 1);
    @(negedge clk); id(5'd0, 5'd0, 0, 0, 1, 0, 5'd2); id_use_hilo = 1'b1;
    expect_out("mfhi_go", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Second mul/div arriving while the first is still busy.
    @(negedge clk); idle(); id_muldiv = 1'b1;
    expect_out("md2_issue", 2'b00, 2'b00, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); id_muldiv = 1'b1;
      expect_out("md2_wait", 2'b00, 2'b00, 1, 0, 0, 1, 0);
    end
    @(negedge clk); idle(); id_muldiv = 1'b1;
    expect_out("md2_done", 2'b00, 2'b00, 1, 0, 0, 1, 1);
    @(negedge clk); idle(); id_muldiv = 1'b1;
    expect_out("md2_go", 2'b00, 2'b00, 0, 0, 1, 0, 0);

    // Reset while md_cnt=2: busy drops, no done pulse.
    @(negedge clk); idle();
    expect_out("md3_b4", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk); idle();
    expect_out("md3_b3", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk); idle(); rst = 1'b1;
    expect_out("md3_rst", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); rst = 1'b0;
      expect_out("md3_abort", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    end

    // MD_CYCLES=1 instance alongside the main one.
    @(negedge clk); idle(); id_muldiv = 1'b1;
    expect_out("md4_issue", 2'b00, 2'b00, 0, 0, 1, 0, 0);
    check("u1_issue.md_start", u1_md_start, 1'b1);
    check("u1_issue.md_busy",  u1_md_busy,  1'b0);
    check("u1_issue.stall",    u1_stall,    1'b0);
    @(negedge clk); idle();
    expect_out("md4_busy", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    check("u1_one.md_busy",  u1_md_busy, 1'b1);
    check("u1_one.md_done",  u1_md_done, 1'b1);
    check("u1_one.fwda",     u1_fwda,    2'b00);
    check("u1_one.fwdb",     u1_fwdb,    2'b00);
    check("u1_one.flush",    u1_flush,   1'b0);
    @(negedge clk); idle();
    expect_out("md4_busy2", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    check("u1_after.md_busy", u1_md_busy, 1'b0);
    check("u1_after.md_done", u1_md_done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
